// File: rtl/neuron_pkg.sv
// Shared types and constants for the Izhikevich neuron scheduler.
package neuron_pkg;

    localparam int NUM_FIELDS = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_WB,
        ST_EMIT
    } state_t;

    localparam logic [2:0] FLD_A    = 3'd0;
    localparam logic [2:0] FLD_B    = 3'd1;
    localparam logic [2:0] FLD_C    = 3'd2;
    localparam logic [2:0] FLD_D    = 3'd3;
    localparam logic [2:0] FLD_I    = 3'd4;
    localparam logic [2:0] FLD_V    = 3'd5;
    localparam logic [2:0] FLD_U    = 3'd6;
    localparam logic [2:0] FLD_RSVD = 3'd7;

    localparam logic [31:0] V_RESET = 32'hC2820000;  // -65.0
    localparam logic [31:0] U_RESET = 32'hC1500000;  // -13.0
    localparam logic [31:0] F_ZERO  = 32'h00000000;
    localparam logic [31:0] F_TEN   = 32'h41200000;  // 10.0

    // Per-neuron record; field code k maps to write-mask bit k.
    typedef struct packed {
        logic [31:0] u;
        logic [31:0] v;
        logic [31:0] i;
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] b;
        logic [31:0] a;
    } nrn_rec_t;

    localparam nrn_rec_t REC_RESET = '{u: U_RESET, v: V_RESET, i: F_ZERO,
                                       d: F_ZERO, c: F_ZERO, b: F_ZERO, a: F_ZERO};

    function automatic logic [NUM_FIELDS-1:0] fld_mask(input logic [2:0] f);
        return (f == FLD_RSVD) ? '0 : 7'(7'd1 << f);
    endfunction

endpackage

// File: rtl/neuron_param_rf.sv
// Per-neuron parameter/state register file: one masked write port, one
// combinational full-record read port.
module neuron_param_rf
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ID_W-1:0]       i_wid,
    input  logic [NUM_FIELDS-1:0] i_wmask,
    input  nrn_rec_t              i_wrec,
    input  logic [ID_W-1:0]       i_rid,
    output nrn_rec_t              o_rrec
);

    nrn_rec_t [NUM_NEURONS-1:0] r_mem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= {NUM_NEURONS{REC_RESET}};
        end else if (i_we) begin
            if (i_wmask[FLD_A]) r_mem[i_wid].a <= i_wrec.a;
            if (i_wmask[FLD_B]) r_mem[i_wid].b <= i_wrec.b;
            if (i_wmask[FLD_C]) r_mem[i_wid].c <= i_wrec.c;
            if (i_wmask[FLD_D]) r_mem[i_wid].d <= i_wrec.d;
            if (i_wmask[FLD_I]) r_mem[i_wid].i <= i_wrec.i;
            if (i_wmask[FLD_V]) r_mem[i_wid].v <= i_wrec.v;
            if (i_wmask[FLD_U]) r_mem[i_wid].u <= i_wrec.u;
        end
    end

    assign o_rrec = r_mem[i_rid];

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexes one Izhikevich update datapath over NUM_NEURONS virtual
// neurons and streams spike IDs. Optional SPIKE_COUNT_EN adds spike counters.
module neuron_scheduler
    import neuron_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_tick,
    output logic            o_busy,
    output logic            o_tick_overrun,
    input  logic            i_cfg_we,
    input  logic [ID_W+2:0] i_cfg_addr,
    input  logic [31:0]     i_cfg_wdata,
    output logic            o_cfg_ready,
    output logic            o_nrn_start,
    output logic [31:0]     o_nrn_v,
    output logic [31:0]     o_nrn_u,
    output logic [31:0]     o_nrn_i,
    output logic [31:0]     o_nrn_a,
    output logic [31:0]     o_nrn_b,
    output logic [31:0]     o_nrn_c,
    output logic [31:0]     o_nrn_d,
    input  logic            i_nrn_done,
    input  logic [31:0]     i_nrn_v_out,
    input  logic [31:0]     i_nrn_u_out,
    input  logic            i_nrn_spiked,
    output logic            o_spike_valid,
    output logic [ID_W-1:0] o_spike_id,
    input  logic            i_spike_ready
`ifdef SPIKE_COUNT_EN
    ,
    output logic [15:0]     o_spike_count,
    output logic [31:0]     o_spike_total
`endif
);

    // Reset asserts asynchronously, releases synchronously to i_clk.
    logic r_rst_meta, r_rst_sync;
    logic w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end
    assign w_rst_n = r_rst_sync;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_idx;
    logic            r_pending, r_overrun;
    logic [31:0]     r_v_cap, r_u_cap;
    logic            r_spk_cap;
    nrn_rec_t        r_ops;
    logic [ID_W-1:0] r_spike_id;

    logic            w_last, w_go, w_hs, w_advance;
    logic            w_we;
    logic [ID_W-1:0] w_wid;
    logic [NUM_FIELDS-1:0] w_wmask;
    nrn_rec_t        w_wrec, w_rrec;

    assign w_last    = (r_idx == ID_W'(NUM_NEURONS - 1));
    assign w_go      = (r_state == ST_IDLE) && (i_tick || r_pending);
    assign w_hs      = (r_state == ST_EMIT) && i_spike_ready;
    assign w_advance = ((r_state == ST_WB) && !r_spk_cap) || w_hs;

    always_comb begin
        w_state_nxt   = r_state;
        o_busy        = 1'b1;
        o_cfg_ready   = 1'b0;
        o_nrn_start   = 1'b0;
        o_spike_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                o_busy      = 1'b0;
                o_cfg_ready = 1'b1;
                if (i_tick || r_pending) w_state_nxt = ST_LOAD;
            end
            ST_LOAD:  w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                o_nrn_start = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT:  if (i_nrn_done) w_state_nxt = ST_WB;
            ST_WB: begin
                if (r_spk_cap)   w_state_nxt = ST_EMIT;
                else if (w_last) w_state_nxt = ST_IDLE;
                else             w_state_nxt = ST_LOAD;
            end
            ST_EMIT: begin
                o_spike_valid = 1'b1;
                if (i_spike_ready) w_state_nxt = w_last ? ST_IDLE : ST_LOAD;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
            r_v_cap    <= '0;
            r_u_cap    <= '0;
            r_spk_cap  <= 1'b0;
            r_ops      <= '0;
            r_spike_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            // One tick may queue behind a running sweep; further ones are lost.
            if (w_go) begin
                r_idx     <= '0;
                r_pending <= 1'b0;
            end else if (i_tick && (r_state != ST_IDLE)) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end
            if (w_advance && !w_last) r_idx <= r_idx + ID_W'(1);
            if (r_state == ST_LOAD) r_ops <= w_rrec;
            if ((r_state == ST_WAIT) && i_nrn_done) begin
                r_v_cap   <= i_nrn_v_out;
                r_u_cap   <= i_nrn_u_out;
                r_spk_cap <= i_nrn_spiked;
            end
            if ((r_state == ST_WB) && r_spk_cap) r_spike_id <= r_idx;
        end
    end

    // CFG owns the write port in IDLE, writeback owns it in WB; never both.
    always_comb begin
        if (r_state == ST_WB) begin
            w_we    = 1'b1;
            w_wid   = r_idx;
            w_wmask = fld_mask(FLD_V) | fld_mask(FLD_U);
            w_wrec  = '{u: r_u_cap, v: r_v_cap, default: '0};
        end else begin
            w_we    = i_cfg_we && (r_state == ST_IDLE);
            w_wid   = i_cfg_addr[ID_W+2:3];
            w_wmask = fld_mask(i_cfg_addr[2:0]);
            w_wrec  = nrn_rec_t'({NUM_FIELDS{i_cfg_wdata}});
        end
    end

    neuron_param_rf #(
        .NUM_NEURONS (NUM_NEURONS),
        .ID_W        (ID_W)
    ) u_rf (
        .i_clk   (i_clk),
        .i_rst_n (w_rst_n),
        .i_we    (w_we),
        .i_wid   (w_wid),
        .i_wmask (w_wmask),
        .i_wrec  (w_wrec),
        .i_rid   (r_idx),
        .o_rrec  (w_rrec)
    );

    assign o_nrn_v        = r_ops.v;
    assign o_nrn_u        = r_ops.u;
    assign o_nrn_i        = r_ops.i;
    assign o_nrn_a        = r_ops.a;
    assign o_nrn_b        = r_ops.b;
    assign o_nrn_c        = r_ops.c;
    assign o_nrn_d        = r_ops.d;
    assign o_tick_overrun = r_overrun;
    assign o_spike_id     = r_spike_id;

`ifdef SPIKE_COUNT_EN
    logic [15:0] r_sweep_cnt, r_spike_count;
    logic [31:0] r_spike_total;
    logic        w_to_idle;

    assign w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sweep_cnt   <= '0;
            r_spike_count <= '0;
            r_spike_total <= '0;
        end else begin
            if (w_go)      r_sweep_cnt <= '0;
            else if (w_hs) r_sweep_cnt <= r_sweep_cnt + 16'd1;
            // The final neuron's handshake can coincide with the return to IDLE.
            if (w_to_idle) r_spike_count <= r_sweep_cnt + 16'(w_hs);
            if (w_hs && (r_spike_total != '1)) r_spike_total <= r_spike_total + 32'd1;
        end
    end

    assign o_spike_count = r_spike_count;
    assign o_spike_total = r_spike_total;
`endif

endmodule
